// File: rtl/mult_fu_if.sv
// Shared payload types and the RS/CDB-facing bundle for the pipelined multiply unit.
package mult_fu_pkg;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned PRN_WIDTH     = 6;
    localparam int unsigned ROB_CNT_WIDTH = 5;

    typedef enum logic [1:0] {
        M_MUL    = 2'd0,
        M_MULH   = 2'd1,
        M_MULHSU = 2'd2,
        M_MULHU  = 2'd3
    } mult_func_t;

    typedef struct packed {
        logic                     valid;
        mult_func_t               func;
        logic [XLEN-1:0]          op1;
        logic [XLEN-1:0]          op2;
        logic [PRN_WIDTH-1:0]     dest_prn;
        logic [ROB_CNT_WIDTH-1:0] robn;
    } fu_packet_t;

    typedef struct packed {
        logic                 valid;
        logic [PRN_WIDTH-1:0] dest_prn;
        logic [XLEN-1:0]      value;
    } cdb_packet_t;
endpackage

interface mult_fu_if;
    import mult_fu_pkg::*;

    fu_packet_t               fu_packet;
    logic                     cdb_gnt;
    logic                     squash;
    logic                     avail;
    cdb_packet_t              cdb_req;
    logic [ROB_CNT_WIDTH-1:0] cdb_robn;

    modport master (
        output fu_packet, cdb_gnt, squash,
        input  avail, cdb_req, cdb_robn
    );

    modport slave (
        input  fu_packet, cdb_gnt, squash,
        output avail, cdb_req, cdb_robn
    );
endinterface

// File: rtl/mult_fu.sv
// Elastic multi-stage integer multiplier: each stage folds one multiplier chunk into a
// running 64-bit partial sum; the last stage holds the result as a CDB request until granted.
module mult_fu
    import mult_fu_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4
) (
    input  logic clock,
    input  logic reset,
`ifdef DEBUG_OUT
    output logic [$clog2(NUM_STAGES+1)-1:0] occupancy_out,
`endif
    mult_fu_if.slave fu_if
);

    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CHUNK = PW / NUM_STAGES;
    localparam int unsigned OCC_W = $clog2(NUM_STAGES + 1);
    localparam int unsigned SUM_W = OCC_W + 1;
    localparam int unsigned LAST  = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0]    vld_q, vld_d;
    mult_func_t               func_q   [NUM_STAGES];
    mult_func_t               func_d   [NUM_STAGES];
    logic [PRN_WIDTH-1:0]     dest_q   [NUM_STAGES];
    logic [PRN_WIDTH-1:0]     dest_d   [NUM_STAGES];
    logic [ROB_CNT_WIDTH-1:0] robn_q   [NUM_STAGES];
    logic [ROB_CNT_WIDTH-1:0] robn_d   [NUM_STAGES];
    logic [PW-1:0]            acc_q    [NUM_STAGES];
    logic [PW-1:0]            acc_d    [NUM_STAGES];
    // The output stage never needs the operands again, so they stop one stage early.
    logic [PW-1:0]            mcand_q  [NUM_STAGES-1];
    logic [PW-1:0]            mcand_d  [NUM_STAGES-1];
    logic [PW-1:0]            mplier_q [NUM_STAGES-1];
    logic [PW-1:0]            mplier_d [NUM_STAGES-1];
    logic [OCC_W-1:0]         occ_q, occ_d;

    logic [NUM_STAGES-1:0]    can_acc;
    logic                     retire;
    logic                     op1_sgn, op2_sgn;
    logic [PW-1:0]            op1_ext, op2_ext;
    cdb_packet_t              cdb_c;

    // Operand extension selected by the requested high-half signedness.
    always_comb begin
        op1_sgn = (fu_if.fu_packet.func == M_MULH) || (fu_if.fu_packet.func == M_MULHSU);
        op2_sgn = (fu_if.fu_packet.func == M_MULH);
        op1_ext = op1_sgn ? {{XLEN{fu_if.fu_packet.op1[XLEN-1]}}, fu_if.fu_packet.op1}
                          : {{XLEN{1'b0}}, fu_if.fu_packet.op1};
        op2_ext = op2_sgn ? {{XLEN{fu_if.fu_packet.op2[XLEN-1]}}, fu_if.fu_packet.op2}
                          : {{XLEN{1'b0}}, fu_if.fu_packet.op2};
    end

    always_comb begin
        vld_d    = vld_q;
        func_d   = func_q;
        dest_d   = dest_q;
        robn_d   = robn_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        occ_d    = occ_q;
        can_acc  = '0;

        retire        = vld_q[LAST] & fu_if.cdb_gnt;
        can_acc[LAST] = !vld_q[LAST] || fu_if.cdb_gnt;
        for (int i = int'(NUM_STAGES) - 2; i >= 0; i--) begin
            can_acc[i] = !vld_q[i] || can_acc[i+1];
        end

        // Stage i folds chunk i of the multiplier, which sits in the low bits after shifting.
        for (int i = 1; i < int'(NUM_STAGES); i++) begin
            if (can_acc[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    func_d[i] = func_q[i-1];
                    dest_d[i] = dest_q[i-1];
                    robn_d[i] = robn_q[i-1];
                    acc_d[i]  = acc_q[i-1]
                              + ((mcand_q[i-1] * PW'(mplier_q[i-1][CHUNK-1:0])) << (i * CHUNK));
                end
            end
        end
        for (int i = 1; i < int'(NUM_STAGES) - 1; i++) begin
            if (can_acc[i] && vld_q[i-1]) begin
                mcand_d[i]  = mcand_q[i-1];
                mplier_d[i] = mplier_q[i-1] >> CHUNK;
            end
        end

        if (can_acc[0]) begin
            vld_d[0] = fu_if.fu_packet.valid;
            if (fu_if.fu_packet.valid) begin
                func_d[0]   = fu_if.fu_packet.func;
                dest_d[0]   = fu_if.fu_packet.dest_prn;
                robn_d[0]   = fu_if.fu_packet.robn;
                mcand_d[0]  = op1_ext;
                mplier_d[0] = op2_ext >> CHUNK;
                acc_d[0]    = op1_ext * PW'(op2_ext[CHUNK-1:0]);
            end
        end

        occ_d = occ_q + OCC_W'(fu_if.fu_packet.valid) - OCC_W'(retire);

        if (fu_if.squash) begin
            vld_d = '0;
            occ_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q    <= '0;
            occ_q    <= '0;
            func_q   <= '{default: M_MUL};
            dest_q   <= '{default: '0};
            robn_q   <= '{default: '0};
            acc_q    <= '{default: '0};
            mcand_q  <= '{default: '0};
            mplier_q <= '{default: '0};
        end else begin
            vld_q    <= vld_d;
            occ_q    <= occ_d;
            func_q   <= func_d;
            dest_q   <= dest_d;
            robn_q   <= robn_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // Result view of the output stage; MUL returns the low word, the MULH family the high word.
    always_comb begin
        cdb_c          = '0;
        cdb_c.valid    = vld_q[LAST];
        cdb_c.dest_prn = dest_q[LAST];
        cdb_c.value    = (func_q[LAST] == M_MUL) ? acc_q[LAST][XLEN-1:0] : acc_q[LAST][PW-1:XLEN];
    end

    assign fu_if.cdb_req  = cdb_c;
    assign fu_if.cdb_robn = robn_q[LAST];
    // Credit ignores retirements so RS selection never depends on the grant path.
    assign fu_if.avail    = (SUM_W'(occ_q) + SUM_W'(fu_if.fu_packet.valid)) < SUM_W'(NUM_STAGES);

`ifdef DEBUG_OUT
    assign occupancy_out = occ_q;
`endif

endmodule
